// File: rtl/csoc_test.sv
// Host-side test harness for a CSoC: UART bridge, derived CSoC clock/reset, optional 7-seg display.
// Latency: RX byte reaches the CSoC on the first csoc_clk fall after the stop bit; TX starts 1 clk after capture.
// Backpressure: none; a CSoC write while TX is busy is dropped, and a newer RX byte replaces an undelivered one.
//
// Ports: clk/rst (async active-high), rx/tx host UART 8N1, leds = last CSoC byte,
//        sseg/an display (active-low), csoc_clk/csoc_rstn to the CSoC, csoc_test_se/tm tied 0,
//        csoc_uart_write/csoc_data_i from the CSoC, csoc_uart_read/csoc_data_o to the CSoC.
// Optional feature: define SSEG_EN to enable the 4-digit hex display scan.

module csoc_prescaler #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst,
  output logic csoc_clk,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap      = (cnt == CW'(DIV - 1));
  // Ticks mark the clk cycle whose closing edge toggles csoc_clk.
  assign rise_tick = wrap & ~csoc_clk;
  assign fall_tick = wrap &  csoc_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      csoc_clk <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      csoc_clk <= ~csoc_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module csoc_test #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int CSOC_DIV = 25,
  parameter int RST_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] leds,
  output logic [7:0] sseg,
  output logic [3:0] an,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  input  logic       csoc_uart_write,
  input  logic [7:0] csoc_data_i,
  output logic       csoc_uart_read,
  output logic [7:0] csoc_data_o
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = (BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 : 1;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int RW       = $clog2(RST_HOLD + 1);

  logic rise_tick, fall_tick;

  assign csoc_test_se = 1'b0;
  assign csoc_test_tm = 1'b0;

  csoc_prescaler #(.DIV(CSOC_DIV)) cp0 (
    .clk       (clk),
    .rst       (rst),
    .csoc_clk  (csoc_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // CSoC reset release after RST_HOLD csoc_clk rising edges.
  logic [RW-1:0] rst_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt   <= '0;
      csoc_rstn <= 1'b0;
    end else if (rise_tick && !csoc_rstn) begin
      if (rst_cnt == RW'(RST_HOLD - 1)) csoc_rstn <= 1'b1;
      else                              rst_cnt   <= rst_cnt + 1'b1;
    end
  end

  // ---------------- UART RX ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_state;
  logic          rx_m, rx_s;
  logic          rx_armed;   // set only once the line has been seen idle-high
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_armed <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s) begin
            rx_armed <= 1'b1;
          end else if (rx_armed) begin
            rx_armed <= 1'b0;
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == BW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // A glitch that is high again at mid-start aborts the frame.
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BW'(BAUD_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin  // RX_STOP
          if (rx_cnt == BW'(BAUD_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_done  <= rx_s;   // framing error silently drops the byte
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RX byte hand-off to the CSoC, aligned to csoc_clk falling edges.
  logic [7:0] rx_hold;
  logic       rx_pend;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold        <= '0;
      rx_pend        <= 1'b0;
      csoc_uart_read <= 1'b0;
      csoc_data_o    <= '0;
    end else begin
      if (fall_tick) begin
        csoc_uart_read <= rx_pend;
        if (rx_pend) csoc_data_o <= rx_hold;
      end
      if (rx_done) begin
        rx_hold <= rx_shift;
        rx_pend <= 1'b1;
      end else if (fall_tick) begin
        rx_pend <= 1'b0;
      end
    end
  end

  // ---------------- UART TX ----------------
  logic          tx_busy;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic [8:0]    tx_frame;   // remaining data bits plus stop bit, LSB next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
      tx_frame <= '1;
      leds     <= '0;
    end else if (rise_tick && csoc_uart_write && !tx_busy) begin
      leds     <= csoc_data_i;
      tx_frame <= {1'b1, csoc_data_i};
      tx       <= 1'b0;
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == BW'(BAUD_DIV - 1)) begin
        tx_cnt <= '0;
        if (tx_bitn == 4'd9) begin
          tx_busy <= 1'b0;
          tx      <= 1'b1;
        end else begin
          tx       <= tx_frame[0];
          tx_frame <= {1'b1, tx_frame[8:1]};
          tx_bitn  <= tx_bitn + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- Display ----------------
`ifdef SSEG_EN
  logic [17:0] refresh;
  logic [1:0]  dsel;
  logic [3:0]  nib;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) refresh <= '0;
    else     refresh <= refresh + 1'b1;
  end

  assign dsel = refresh[17:16];
  assign an   = ~(4'b0001 << dsel);

  always_comb begin
    nib = 4'h0;
    case (dsel)
      2'd0:    nib = leds[3:0];
      2'd1:    nib = leds[7:4];
      2'd2:    nib = rx_hold[3:0];
      default: nib = rx_hold[7:4];
    endcase
  end

  // {dp,g,f,e,d,c,b,a}, active-low, dp off.
  always_comb begin
    sseg = 8'hFF;
    case (nib)
      4'h0: sseg = 8'hC0;  4'h1: sseg = 8'hF9;  4'h2: sseg = 8'hA4;  4'h3: sseg = 8'hB0;
      4'h4: sseg = 8'h99;  4'h5: sseg = 8'h92;  4'h6: sseg = 8'h82;  4'h7: sseg = 8'hF8;
      4'h8: sseg = 8'h80;  4'h9: sseg = 8'h90;  4'hA: sseg = 8'h88;  4'hB: sseg = 8'h83;
      4'hC: sseg = 8'hC6;  4'hD: sseg = 8'hA1;  4'hE: sseg = 8'h86;  default: sseg = 8'h8E;
    endcase
  end
`else
  assign sseg = 8'hFF;
  assign an   = 4'hF;
`endif
endmodule

// File: tb/tb_csoc_test.sv
// Bench for csoc_test: random host RX bytes and CSoC writes against a queue-based reference.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_csoc_test;
  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int BD       = CLK_FREQ / BAUD;   // 16 clk per bit
  localparam int CSOC_DIV = 4;
  localparam int RST_HOLD = 5;
  localparam int CP       = 2 * CSOC_DIV;      // csoc_clk period in clk

  logic       clk = 1'b0;
  logic       rst, rx, tx;
  logic [7:0] leds, sseg;
  logic [3:0] an;
  logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic       csoc_uart_write, csoc_uart_read;
  logic [7:0] csoc_data_i, csoc_data_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_leds   = 8'h00;
  logic [7:0] last_valid = 8'h00;   // last well-framed host byte sent

  csoc_test #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .CSOC_DIV(CSOC_DIV), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .leds(leds), .sseg(sseg), .an(an),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_uart_write(csoc_uart_write),
    .csoc_data_i(csoc_data_i), .csoc_uart_read(csoc_uart_read), .csoc_data_o(csoc_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] t[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host sends one 8N1 frame; only a frame with a good stop bit is expected downstream.
  task automatic send_rx(input logic [7:0] d, input logic stopb);
    if (stopb) begin
      exp_rx.push_back(d);
      last_valid = d;
    end
    hold_rx(1'b0, BD);
    for (int i = 0; i < 8; i++) hold_rx(d[i], BD);
    hold_rx(stopb, BD);
    hold_rx(1'b1, 3 * BD);
  endtask

  // Write request held for exactly one csoc_clk period, spanning one rising edge.
  task automatic do_write(input logic [7:0] d);
    @(negedge csoc_clk); #1;
    csoc_uart_write = 1'b1;
    csoc_data_i     = d;
    @(negedge csoc_clk); #1;
    csoc_uart_write = 1'b0;
  endtask

  // Monitor: CSoC-side RX strobe and data.
  initial begin : rx_mon
    logic prev;
    int   len;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(posedge clk); #2;
      if (csoc_uart_read === 1'b1 && !prev) begin
        len = 1;
        if (exp_rx.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_strobe: unexpected strobe with data 0x%0h, none expected", csoc_data_o);
        end else begin
          check("rx_data", csoc_data_o, exp_rx.pop_front());
        end
      end else if (csoc_uart_read === 1'b1) begin
        len++;
      end else if (prev) begin
        check("rx_strobe_len", len, CP);
      end
      prev = (csoc_uart_read === 1'b1);
    end
  end

  // Monitor: decode host TX frames.
  initial begin : tx_mon
    logic [7:0] d;
    forever begin
      @(negedge tx);
      repeat (BD / 2) @(posedge clk); #2;
      check("tx_start", tx, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(posedge clk); #2;
        d[i] = tx;
      end
      repeat (BD) @(posedge clk); #2;
      check("tx_stop", tx, 1'b1);
      if (exp_tx.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_frame: unexpected frame 0x%0h, none expected", d);
      end else begin
        check("tx_data", d, exp_tx.pop_front());
      end
      check("leds", leds, exp_leds);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  initial begin : main
    int rises, r1, r2, cyc;
    logic pc;
    logic [7:0] d;

    rst = 1'b1; rx = 1'b0; csoc_uart_write = 1'b0; csoc_data_i = 8'h00;
    repeat (3) @(posedge clk); #2;
    check("rst_tx", tx, 1'b1);
    check("rst_csoc_clk", csoc_clk, 1'b0);
    check("rst_csoc_rstn", csoc_rstn, 1'b0);
    check("rst_read", csoc_uart_read, 1'b0);
    check("rst_data_o", csoc_data_o, 8'h00);
    check("rst_leds", leds, 8'h00);
    check("rst_se", csoc_test_se, 1'b0);
    check("rst_tm", csoc_test_tm, 1'b0);
`ifdef SSEG_EN
    check("rst_an", an, 4'b1110);
    check("rst_sseg", sseg, 8'hC0);
`else
    check("rst_an", an, 4'hF);
    check("rst_sseg", sseg, 8'hFF);
`endif

    // Release reset with rx held low: CSoC reset timing, no RX delivery.
    @(posedge clk); #1;
    rst = 1'b0;
    rises = 0; r1 = -1; r2 = -1; pc = 1'b0;
    for (cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #2;
      if (csoc_clk && !pc) begin
        rises++;
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      pc = csoc_clk;
      if (csoc_rstn) break;
    end
    check("rstn_rises", rises, RST_HOLD);
    check("csoc_clk_period", r2 - r1, CP);
    repeat (20 * BD) @(posedge clk); #1;
    check("rstn_stays", csoc_rstn, 1'b1);
    hold_rx(1'b1, 2 * BD);

    fork
      begin : rx_thread
        send_rx(8'hA5, 1'b1);
        send_rx(8'h12, 1'b0);
        repeat (2 * CP) @(posedge clk); #1;
        check("frame_err_data_o", csoc_data_o, 8'hA5);
        for (int k = 0; k < 8; k++) begin
          d = 8'($urandom_range(0, 255));
          send_rx(d, ($urandom_range(0, 3) != 0));
          repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        send_rx(8'h12, 1'b1);
      end
      begin : tx_thread
        // Each pair: accepted write on idle TX, optional write while it is still sending.
        for (int k = 0; k < 7; k++) begin
          d = (k == 0) ? 8'h3C : 8'($urandom_range(0, 255));
          if (k == 6) d = 8'h3C;
          exp_tx.push_back(d);
          exp_leds = d;
          do_write(d);
          if (k == 0 || $urandom_range(0, 1) == 1) begin
            repeat ((k == 0) ? 2 : $urandom_range(0, 9)) @(negedge csoc_clk);
            do_write((k == 0) ? 8'h55 : 8'($urandom_range(0, 255)));
          end
          repeat (30) @(negedge csoc_clk);
        end
      end
    join

    repeat (20 * BD) @(posedge clk); #2;
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("final_leds", leds, exp_leds);
    check("final_data_o", csoc_data_o, last_valid);
    check("tx_idle", tx, 1'b1);
`ifdef SSEG_EN
    case (an)
      4'b1110: check("sseg_d0", sseg, seg_of(exp_leds[3:0]));
      4'b1101: check("sseg_d1", sseg, seg_of(exp_leds[7:4]));
      4'b1011: check("sseg_d2", sseg, seg_of(last_valid[3:0]));
      4'b0111: check("sseg_d3", sseg, seg_of(last_valid[7:4]));
      default: check("an_onehot", an, 4'b1110);
    endcase
`else
    check("an_off", an, 4'hF);
    check("sseg_off", sseg, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
